// File: rtl/ecp_rst_pkg.sv
// Shared types and helpers for the PLL bring-up supervisor.
package ecp_rst_pkg;

    typedef enum logic [1:0] {
        PLLRST    = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Width of a down-counter able to hold the largest of three load values.
    function automatic int ctr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchroniser with asynchronous active-low clear.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; the last flop is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ecp_pll_reset_seq.sv
// PLL bring-up supervisor: pulses the PLL reset, qualifies lock, releases the design reset.
module ecp_pll_reset_seq
    import ecp_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 4096,
    parameter int CNT_W         = 8
) (
    input  logic             clkin,
    input  logic             resetn,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int               CTR_W        = ctr_width(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CTR_W-1:0] LOAD_RST     = CTR_W'(RST_PULSE);
    localparam logic [CTR_W-1:0] LOAD_TIMEOUT = CTR_W'(LOCK_TIMEOUT);
    localparam logic [CTR_W-1:0] LOAD_STABLE  = CTR_W'(STABLE_CYCLES);
    localparam logic [CTR_W-1:0] CTR_ONE      = CTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    seq_state_e       state, state_next;
    logic [CTR_W-1:0] ctr, ctr_next;
    logic             lock_s;
    logic             retry_inc;
    logic             loss_inc;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clkin),
        .rst_n (resetn),
        .d     (locked),
        .q     (lock_s)
    );

    // Next-state logic; the shared down-counter is reloaded on every state entry.
    always_comb begin
        state_next = state;
        ctr_next   = ctr - CTR_ONE;
        retry_inc  = 1'b0;
        loss_inc   = 1'b0;
        unique case (state)
            PLLRST: begin
                if (ctr == CTR_ONE) begin
                    state_next = WAIT_LOCK;
                    ctr_next   = LOAD_TIMEOUT;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout that expires on the same cycle.
                if (lock_s) begin
                    state_next = STABLE;
                    ctr_next   = LOAD_STABLE;
                end else if (ctr == CTR_ONE) begin
                    state_next = PLLRST;
                    ctr_next   = LOAD_RST;
                    retry_inc  = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    ctr_next   = LOAD_TIMEOUT;
                end else if (ctr == CTR_ONE) begin
                    state_next = RUN;
                    ctr_next   = '0;
                end
            end
            RUN: begin
                ctr_next = ctr;
                // No PLL reset on a loss; the WAIT_LOCK timeout retries a PLL that stays down.
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    ctr_next   = LOAD_TIMEOUT;
                    loss_inc   = 1'b1;
                end
            end
            default: begin
                state_next = PLLRST;
                ctr_next   = LOAD_RST;
            end
        endcase
    end

    // State, counter and outputs decoded from the next state so they move together.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state     <= PLLRST;
            ctr       <= LOAD_RST;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state     <= state_next;
            ctr       <= ctr_next;
            pll_rst   <= (state_next == PLLRST);
            sys_rst_n <= (state_next == RUN);
            ready     <= (state_next == RUN);
        end
    end

    // Sticky loss flag and saturating event counters, cleared only by resetn.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lock_lost <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            if (loss_inc) lock_lost <= 1'b1;
            if (retry_inc && (retry_cnt != CNT_MAX)) retry_cnt <= retry_cnt + 1'b1;
            if (loss_inc && (loss_cnt != CNT_MAX))   loss_cnt  <= loss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecp_pll_reset_seq.sv
// Self-checking bench for ecp_pll_reset_seq: directed scenarios plus random lock activity.
module tb_ecp_pll_reset_seq;

    localparam int SYNC_STAGES   = 2;
    localparam int RST_PULSE     = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 32;
    localparam int CNT_W         = 4;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;

    logic             clkin  = 1'b0;
    logic             resetn = 1'b0;
    logic             locked = 1'b0;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic             lock_lost;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    int compareCount = 0;
    int failCount    = 0;

    // Behavioural reference: named phase, cycles spent in it, event tallies, lock delay line.
    string phase;
    int    elapsed;
    int    mRetries;
    int    mLosses;
    bit    mLost;
    bit    lockPipe[$];

    always #20 clkin = ~clkin;

    ecp_pll_reset_seq #(
        .SYNC_STAGES   (SYNC_STAGES),
        .RST_PULSE     (RST_PULSE),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clkin     (clkin),
        .resetn    (resetn),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        phase    = "reset";
        elapsed  = 0;
        mRetries = 0;
        mLosses  = 0;
        mLost    = 1'b0;
        lockPipe = {};
        for (int i = 0; i < SYNC_STAGES; i++) lockPipe.push_back(1'b0);
    endtask

    // One rising edge of the reference: what the supervisor sees is locked delayed by SYNC_STAGES edges.
    task automatic modelEdge();
        bit seen;
        seen = lockPipe.pop_front();
        lockPipe.push_back(locked);
        if (phase == "reset") begin
            elapsed++;
            if (elapsed == RST_PULSE) begin phase = "waiting"; elapsed = 0; end
        end else if (phase == "waiting") begin
            if (seen) begin
                phase = "qualifying"; elapsed = 0;
            end else begin
                elapsed++;
                if (elapsed == LOCK_TIMEOUT) begin
                    phase = "reset"; elapsed = 0;
                    mRetries = (mRetries < CNT_MAX) ? mRetries + 1 : CNT_MAX;
                end
            end
        end else if (phase == "qualifying") begin
            if (!seen) begin
                phase = "waiting"; elapsed = 0;
            end else begin
                elapsed++;
                if (elapsed == STABLE_CYCLES) begin phase = "running"; elapsed = 0; end
            end
        end else begin
            if (!seen) begin
                phase = "waiting"; elapsed = 0; mLost = 1'b1;
                mLosses = (mLosses < CNT_MAX) ? mLosses + 1 : CNT_MAX;
            end
        end
    endtask

    function automatic logic [31:0] expectedVec();
        logic run;
        run = (phase == "running");
        return {20'd0, (phase == "reset"), run, run, mLost, 4'(mRetries), 4'(mLosses)};
    endfunction

    function automatic logic [31:0] observedVec();
        return {20'd0, pll_rst, sys_rst_n, ready, lock_lost, retry_cnt, loss_cnt};
    endfunction

    // Advance n clock edges, stepping the model and comparing all outputs 1 ns after each edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clkin);
            if (resetn) modelEdge();
            #1;
            checkOutput("cycle_outputs", observedVec(), expectedVec());
        end
    endtask

    // Hold reset for two edges, then release it away from the clock edge.
    task automatic holdReset();
        resetn = 1'b0;
        modelReset();
        applyStimulus(2);
        checkOutput("reset_pll_rst", pll_rst, 1);
        checkOutput("reset_sys_rst_n", sys_rst_n, 0);
        checkOutput("reset_counts", {retry_cnt, loss_cnt}, 0);
        resetn = 1'b1;
    endtask

    // Step until the model is at the given qualification count, within a cycle budget.
    task automatic waitQualifying(input int count, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (phase == "qualifying" && elapsed == count) found = 1'b1;
            else applyStimulus(1);
        end
        checkOutput(tag, found, 1);
    endtask

    initial begin
        $display("[TB] start");
        modelReset();

        // Clean bring-up: lock appears at cycle 10, STABLE entered at edge 13, release at edge 45.
        locked = 1'b0;
        holdReset();
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(1);
            if (c <= RST_PULSE - 1) checkOutput("bringup_pll_rst_high", pll_rst, 1);
            if (c == RST_PULSE)     checkOutput("bringup_pll_rst_low", pll_rst, 0);
        end
        locked = 1'b1;
        applyStimulus(34);
        checkOutput("bringup_ready_early", {sys_rst_n, ready}, 2'b00);
        applyStimulus(1);
        checkOutput("bringup_ready", {sys_rst_n, ready}, 2'b11);
        checkOutput("bringup_retry", retry_cnt, 0);

        // Loss in RUN: release drops SYNC_STAGES+1 edges after locked falls.
        applyStimulus(5);
        locked = 1'b0;
        applyStimulus(SYNC_STAGES);
        checkOutput("loss_still_up", sys_rst_n, 1);
        applyStimulus(1);
        checkOutput("loss_sys_rst_n", sys_rst_n, 0);
        checkOutput("loss_flag", lock_lost, 1);
        checkOutput("loss_cnt", loss_cnt, 1);
        locked = 1'b1;
        applyStimulus(34);
        checkOutput("relock_early", ready, 0);
        applyStimulus(1);
        checkOutput("relock_ready", ready, 1);
        checkOutput("relock_flag_sticky", lock_lost, 1);

        // Glitch during STABLE: 3-cycle drop at count 20 restarts the full qualification.
        locked = 1'b0;
        holdReset();
        locked = 1'b1;
        waitQualifying(20, "glitch_reach_stable");
        locked = 1'b0;
        applyStimulus(3);
        locked = 1'b1;
        applyStimulus(34);
        checkOutput("glitch_no_early_release", ready, 0);
        applyStimulus(1);
        checkOutput("glitch_release", ready, 1);

        // Never locks: pll_rst pulses every RST_PULSE+LOCK_TIMEOUT cycles, retries count up.
        locked = 1'b0;
        holdReset();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(RST_PULSE + LOCK_TIMEOUT - 1);
            checkOutput("nolock_gap", pll_rst, 0);
            applyStimulus(1);
            checkOutput("nolock_pulse", pll_rst, 1);
            checkOutput("nolock_retry", retry_cnt, k);
        end
        applyStimulus(500 - 4 * (RST_PULSE + LOCK_TIMEOUT));
        checkOutput("nolock_sys_rst_n", sys_rst_n, 0);

        // Saturation: sixteen more timeouts bring the total to 20.
        applyStimulus(16 * (RST_PULSE + LOCK_TIMEOUT));
        checkOutput("retry_saturated", retry_cnt, CNT_MAX);

        // Asynchronous reset mid-STABLE, with no clock edge in between.
        locked = 1'b1;
        waitQualifying(10, "async_reach_stable");
        #7;
        resetn = 1'b0;
        modelReset();
        #1;
        checkOutput("async_pll_rst", pll_rst, 1);
        checkOutput("async_sys_rst_n", sys_rst_n, 0);
        checkOutput("async_counts", {retry_cnt, loss_cnt}, 0);
        applyStimulus(2);
        resetn = 1'b1;

        // Random lock activity with occasional mid-sequence resets, checked cycle by cycle.
        for (int r = 0; r < 50; r++) begin
            locked = ($urandom_range(0, 2) != 0);
            applyStimulus($urandom_range(1, 80));
            if ($urandom_range(0, 14) == 0) begin
                #($urandom_range(2, 15));
                resetn = 1'b0;
                modelReset();
                #1;
                checkOutput("random_async_reset", observedVec(), expectedVec());
                applyStimulus(1);
                resetn = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
